// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the `pc` module.
// Chooses jumpEn/target each cycle to advance, branch, call, return, stall or
// freeze the program counter. Owns the IDLE/RUN/HALT state, an optional
// circular return-address stack and a retired-instruction counter.
// Build option: define PC_SEQ_RAS_EN to include the return-address stack;
// without it, calls act as plain jumps and returns fall through sequentially.
module pc_sequencer #(
  parameter int D     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] programCounter,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         brEn,
  input  logic         brTaken,
  input  logic [7:0]   brOffset,
  input  logic         jmpEn,
  input  logic         callEn,
  input  logic         retEn,
  input  logic [D-1:0] jmpTarget,
  output logic         jumpEn,
  output logic [D-1:0] target,
  output logic         running,
  output logic         halted,
  output logic         rasErr,
  output logic [15:0]  instCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t       state;
  state_t       next_state;
  logic         retire;
  logic [D-1:0] br_target;

  // Reject stack sizes the circular pointer arithmetic cannot wrap correctly.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_sequencer: DEPTH must be a power of two, at least 2");
  end

  // Branch target: sign-extended offset added with natural modulo-2^D wrap.
  assign br_target = programCounter + D'($signed(brOffset));

`ifdef PC_SEQ_RAS_EN
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [D-1:0] ras_mem [DEPTH];
  logic [AW-1:0] ras_wp;      // next slot to write; top of stack is ras_wp-1
  logic [CW-1:0] ras_cnt;     // valid entries, saturates at DEPTH
  logic [D-1:0]  ras_top;
  logic [D-1:0]  pc_plus1;
  logic          do_push;
  logic          do_pop;
  logic          ras_uflow;

  assign ras_top  = ras_mem[ras_wp - AW'(1)];
  assign pc_plus1 = programCounter + D'(1);
`endif

  // Next-PC decision and side-effect requests, combinational from state and inputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    jumpEn     = 1'b1;
    target     = '0;
    next_state = state;
    retire     = 1'b0;
`ifdef PC_SEQ_RAS_EN
    do_push    = 1'b0;
    do_pop     = 1'b0;
    ras_uflow  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) next_state = S_RUN;
      end
      S_HALT: begin
        target = programCounter;
        if (start) next_state = S_IDLE;
      end
      S_RUN: begin
        if (stall) begin
          target = programCounter;
        end else begin
          retire = 1'b1;
          if (halt) begin
            target     = programCounter;
            next_state = S_HALT;
          end else if (retEn) begin
`ifdef PC_SEQ_RAS_EN
            if (ras_cnt != '0) begin
              do_pop = 1'b1;
              target = ras_top;
            end else begin
              jumpEn    = 1'b0;
              ras_uflow = 1'b1;
            end
`else
            jumpEn = 1'b0;
`endif
          end else if (callEn) begin
`ifdef PC_SEQ_RAS_EN
            do_push = 1'b1;
`endif
            target = jmpTarget;
          end else if (jmpEn) begin
            target = jmpTarget;
          end else if (brEn && brTaken) begin
            target = br_target;
          end else begin
            jumpEn = 1'b0;
          end
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Run/halt state and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state     <= S_IDLE;
      instCount <= '0;
    end else begin
      state <= next_state;
      if (retire) instCount <= instCount + 16'd1;
    end
  end

  assign running = (state == S_RUN);
  assign halted  = (state == S_HALT);

`ifdef PC_SEQ_RAS_EN
  // Stack storage: written on push only.
  // NOTE: the array is not reset; ras_cnt alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) ras_mem[ras_wp] <= pc_plus1;
  end

  // Stack pointer, occupancy and sticky overflow/underflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_wp  <= '0;
      ras_cnt <= '0;
      rasErr  <= 1'b0;
    end else begin
      if (do_push) begin
        ras_wp <= ras_wp + AW'(1);
        // When full, the write lands on the oldest entry and depth stays at DEPTH.
        if (ras_cnt == CW'(DEPTH)) rasErr <= 1'b1;
        else ras_cnt <= ras_cnt + CW'(1);
      end else if (do_pop) begin
        ras_wp  <= ras_wp - AW'(1);
        ras_cnt <= ras_cnt - CW'(1);
      end
      if (ras_uflow) rasErr <= 1'b1;
    end
  end
`else
  assign rasErr = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized bench for pc_sequencer with a queue-based
// reference model and a simple pc register closing the loop.
module tb_pc_sequencer;

  localparam int D     = 10;
  localparam int DEPTH = 4;

  logic         clk;
  logic         reset;
  logic [D-1:0] pc_q;
  logic         start, stall, halt, brEn, brTaken, jmpEn, callEn, retEn;
  logic [7:0]   brOffset;
  logic [D-1:0] jmpTarget;
  logic         jumpEn;
  logic [D-1:0] target;
  logic         running, halted, rasErr;
  logic [15:0]  instCount;

  pc_sequencer #(.D(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .programCounter(pc_q),
    .start(start), .stall(stall), .halt(halt),
    .brEn(brEn), .brTaken(brTaken), .brOffset(brOffset),
    .jmpEn(jmpEn), .callEn(callEn), .retEn(retEn), .jmpTarget(jmpTarget),
    .jumpEn(jumpEn), .target(target), .running(running), .halted(halted),
    .rasErr(rasErr), .instCount(instCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_HALT} mstate_t;
  mstate_t      m_state;
  logic [D-1:0] m_ras[$];
  logic         m_err;
  int           m_cnt;

  logic         e_je, e_tchk;
  logic [D-1:0] e_t;
  mstate_t      p_next;
  logic         p_push, p_pop, p_err, p_retire;

  task automatic model_reset();
    m_state = M_IDLE;
    m_ras.delete();
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_eval();
    int v;
    e_je = 1'b1; e_t = '0; e_tchk = 1'b1;
    p_next = m_state; p_push = 0; p_pop = 0; p_err = 0; p_retire = 0;
    case (m_state)
      M_IDLE: if (start) p_next = M_RUN;
      M_HALT: begin
        e_t = pc_q;
        if (start) p_next = M_IDLE;
      end
      default: begin
        if (stall) e_t = pc_q;
        else begin
          p_retire = 1'b1;
          if (halt) begin
            e_t = pc_q;
            p_next = M_HALT;
          end else if (retEn) begin
`ifdef PC_SEQ_RAS_EN
            if (m_ras.size() > 0) begin
              e_t = m_ras[$];
              p_pop = 1'b1;
            end else begin
              e_je = 1'b0; e_tchk = 1'b0; p_err = 1'b1;
            end
`else
            e_je = 1'b0; e_tchk = 1'b0;
`endif
          end else if (callEn) begin
            e_t = jmpTarget;
`ifdef PC_SEQ_RAS_EN
            p_push = 1'b1;
`endif
          end else if (jmpEn) begin
            e_t = jmpTarget;
          end else if (brEn && brTaken) begin
            v = int'(pc_q) + int'($signed(brOffset));
            v = ((v % 1024) + 1024) % 1024;
            e_t = v[D-1:0];
          end else begin
            e_je = 1'b0;
          end
        end
      end
    endcase
  endtask

  task automatic model_commit();
    int ra;
    if (p_push) begin
      ra = (int'(pc_q) + 1) % 1024;
      m_ras.push_back(ra[D-1:0]);
      if (m_ras.size() > DEPTH) begin
        void'(m_ras.pop_front());
        m_err = 1'b1;
      end
    end
    if (p_pop) void'(m_ras.pop_back());
    if (p_err) m_err = 1'b1;
    if (p_retire) m_cnt = (m_cnt + 1) % 65536;
    m_state = p_next;
  endtask

  // One clock: compare against the model, then the pc register follows the DUT.
  task automatic step();
    logic [D-1:0] nxt;
    #2;
    model_eval();
    check("jumpEn", 32'(jumpEn), 32'(e_je));
    if (e_tchk) check("target", 32'(target), 32'(e_t));
    check("running", 32'(running), 32'(m_state == M_RUN));
    check("halted", 32'(halted), 32'(m_state == M_HALT));
    check("rasErr", 32'(rasErr), 32'(m_err));
    check("instCount", 32'(instCount), 32'(m_cnt));
    model_commit();
    nxt = jumpEn ? target : pc_q + D'(1);
    @(posedge clk);
    #1;
    pc_q = nxt;
  endtask

  task automatic clear();
    start = 0; stall = 0; halt = 0; brEn = 0; brTaken = 0; brOffset = '0;
    jmpEn = 0; callEn = 0; retEn = 0; jmpTarget = '0;
  endtask

  task automatic jump_to(input logic [D-1:0] a);
    clear(); jmpEn = 1; jmpTarget = a; step(); clear();
  endtask

  task automatic call_to(input logic [D-1:0] a);
    clear(); callEn = 1; jmpTarget = a; step(); clear();
  endtask

  task automatic do_ret();
    clear(); retEn = 1; step(); clear();
  endtask

  task automatic rand_inputs();
    start     = ($urandom_range(0, 9) == 0);
    stall     = ($urandom_range(0, 6) == 0);
    halt      = ($urandom_range(0, 39) == 0);
    brEn      = $urandom_range(0, 1) == 1;
    brTaken   = $urandom_range(0, 1) == 1;
    brOffset  = 8'($urandom);
    jmpEn     = ($urandom_range(0, 9) == 0);
    callEn    = ($urandom_range(0, 7) == 0);
    retEn     = ($urandom_range(0, 7) == 0);
    jmpTarget = D'($urandom);
  endtask

  task automatic ensure_run();
    for (int i = 0; i < 4; i++) begin
      clear();
      if (m_state == M_RUN) break;
      start = 1;
      step();
    end
    clear();
  endtask

  initial begin
    clear();
    pc_q  = '0;
    reset = 1'b0;
    model_reset();
    #3;
    check("rst_jumpEn", 32'(jumpEn), 32'd1);
    check("rst_target", 32'(target), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_rasErr", 32'(rasErr), 32'd0);
    check("rst_instCount", 32'(instCount), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // start pulse: PC held at 0, then five sequential fetches 0..4
    start = 1; step(); clear();
    check("pc_after_start", 32'(pc_q), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("seq_pc", 32'(pc_q), 32'(i));
      step();
    end
    check("seq_instCount", 32'(instCount), 32'd5);
    check("seq_running", 32'(running), 32'd1);

    // branches, including a wrap past 2^D
    brEn = 1; brTaken = 1; brOffset = 8'hFD; step(); clear();
    check("br_back", 32'(pc_q), 32'd2);
    jump_to(10'd1020);
    brEn = 1; brTaken = 1; brOffset = 8'd10; step(); clear();
    check("br_wrap", 32'(pc_q), 32'd6);
    brEn = 1; brTaken = 0; brOffset = 8'd50; step(); clear();
    check("br_not_taken", 32'(pc_q), 32'd7);

    // call at 7 to 100, return at 103
    call_to(10'd100);
    check("call_pc", 32'(pc_q), 32'd100);
    step(); step(); step();
    check("pre_ret_pc", 32'(pc_q), 32'd103);
    do_ret();
`ifdef PC_SEQ_RAS_EN
    check("ret_pc", 32'(pc_q), 32'd8);
`else
    check("ret_pc", 32'(pc_q), 32'd104);
`endif

    // five nested calls into a four-deep stack, then five returns
    call_to(10'd200); call_to(10'd300); call_to(10'd400);
    call_to(10'd500); call_to(10'd600);
`ifdef PC_SEQ_RAS_EN
    check("ovf_rasErr", 32'(rasErr), 32'd1);
    do_ret(); check("ret1", 32'(pc_q), 32'd501);
    do_ret(); check("ret2", 32'(pc_q), 32'd401);
    do_ret(); check("ret3", 32'(pc_q), 32'd301);
    do_ret(); check("ret4", 32'(pc_q), 32'd201);
    do_ret(); check("ret5_seq", 32'(pc_q), 32'd202);
`else
    check("ovf_rasErr", 32'(rasErr), 32'd0);
    do_ret(); check("ret1", 32'(pc_q), 32'd601);
    for (int i = 0; i < 4; i++) do_ret();
    check("ret5_seq", 32'(pc_q), 32'd605);
`endif

    // stall with a competing jump, then halt at 9
    jump_to(10'd9);
    begin
      logic [15:0] cnt_before;
      cnt_before = instCount;
      for (int i = 0; i < 3; i++) begin
        clear(); stall = 1; jmpEn = 1; jmpTarget = 10'd77; halt = (i == 1);
        step();
        check("stall_pc", 32'(pc_q), 32'd9);
      end
      check("stall_count", 32'(instCount), 32'(cnt_before));
    end
    clear(); halt = 1; step(); clear();
    check("halt_pc", 32'(pc_q), 32'd9);
    check("halt_flag", 32'(halted), 32'd1);
    jmpEn = 1; jmpTarget = 10'd55; step(); step(); clear();
    check("halt_frozen", 32'(pc_q), 32'd9);
    start = 1; step(); clear();
    check("halt_to_idle", 32'(halted), 32'd0);
    step();
    check("idle_pc0", 32'(pc_q), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end
    clear();

    // asynchronous reset in the middle of a RUN cycle at PC 40
    ensure_run();
    jump_to(10'd40);
    check("pre_reset_pc", 32'(pc_q), 32'd40);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_jumpEn", 32'(jumpEn), 32'd1);
    check("mid_rst_target", 32'(target), 32'd0);
    check("mid_rst_running", 32'(running), 32'd0);
    check("mid_rst_halted", 32'(halted), 32'd0);
    check("mid_rst_rasErr", 32'(rasErr), 32'd0);
    check("mid_rst_instCount", 32'(instCount), 32'd0);
    model_reset();
    begin
      logic [D-1:0] nxt;
      nxt = jumpEn ? target : pc_q + D'(1);
      @(posedge clk); #1;
      pc_q = nxt;
    end
    check("post_rst_pc", 32'(pc_q), 32'd0);
    reset = 1'b1;

    // return with an empty (or absent) stack falls through sequentially
    start = 1; step(); clear();
    jump_to(10'd12);
    do_ret();
    check("ret_empty_seq", 32'(pc_q), 32'd13);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the `pc` module: each cycle it decides `jumpEn`/`target` so the counter advances, branches, calls, returns, stalls or freezes. It owns run/halt state, a small return-address stack (RAS) and a retired-instruction counter. It sits between decode/fetch-stall logic and `pc`, whose `programCounter` it reads back.

## Interface
- `D`, 10, PC width; must match `pc`.
- `DEPTH`, 4, RAS entries; power of two, at least 2.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state.
- `programCounter`  in  D  current PC from `pc`.
- `start`  in  1  leave IDLE/HALT.
- `stall`  in  1  fetched instruction not valid this cycle.
- `halt`  in  1  instruction at `programCounter` is HALT.
- `brEn`  in  1  conditional branch decoded.
- `brTaken`  in  1  branch condition true.
- `brOffset`  in  8  signed PC-relative offset.
- `jmpEn`  in  1  absolute jump.
- `callEn`  in  1  call to `jmpTarget`.
- `retEn`  in  1  return.
- `jmpTarget`  in  D  absolute target for jump/call.
- `jumpEn`  out  1  to `pc`.
- `target`  out  D  to `pc`.
- `running`  out  1  state is RUN.
- `halted`  out  1  state is HALT.
- `rasErr`  out  1  sticky RAS overflow/underflow flag.
- `instCount`  out  16  retired instructions.

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE, RAS empty, `rasErr`=0, `instCount`=0.
- IDLE: `jumpEn`=1, `target`=0 (holds PC at 0). `start`=1 -> RUN.
- HALT: `jumpEn`=1, `target`=`programCounter` (freeze), `halted`=1. `start`=1 -> IDLE.
- RUN, first matching rule wins:
  - `stall`: `jumpEn`=1, `target`=`programCounter`; nothing else acts, nothing retires.
  - `halt`: freeze as in HALT; next state HALT; retires.
  - `retEn`: RAS non-empty -> pop, `target`=popped value, `jumpEn`=1; empty -> `jumpEn`=0, `rasErr` set.
  - `callEn`: push `programCounter`+1, `target`=`jmpTarget`, `jumpEn`=1.
  - `jmpEn`: `target`=`jmpTarget`, `jumpEn`=1.
  - `brEn` and `brTaken`: `target`=`programCounter`+sext(`brOffset`), `jumpEn`=1.
  - otherwise: `jumpEn`=0, `target`=0.
- All PC arithmetic wraps modulo 2^D.
- RAS is circular. Push when full overwrites the oldest entry, keeps depth at DEPTH and sets `rasErr`.
- Any non-stall RUN cycle retires: `instCount`+1, wrapping at 16 bits.
- Outside RUN, the request inputs are ignored.

## Timing
- `jumpEn`/`target` are combinational from state and inputs; `pc` applies them at the next rising edge, giving one-cycle redirect.
- State, RAS, `rasErr` and `instCount` update on the rising edge.
- `running`/`halted` decode registered state.
- Reset outputs: `jumpEn`=1, `target`=0, `running`=0, `halted`=0, `rasErr`=0, `instCount`=0.
- `start` asserted in IDLE: PC still held at 0 that cycle. First RUN cycle fetches address 0.
- Reset asserted mid-RUN: immediate return to IDLE. RAS contents discarded and count cleared.
- A HALT raised while `stall`=1 is ignored; decode re-presents it.

## Configuration
- `PC_SEQ_RAS_EN` defined: RAS, call push and return pop as above.
- Undefined:
  - No stack storage.
  - `callEn` behaves as `jmpEn`, with no push.
  - `retEn` gives `jumpEn`=0 (sequential).
  - `rasErr` tied 0.

## Test plan
- Reset, then `start` pulse, then 5 idle cycles with no requests -> PC 0,1,2,3,4; `instCount`=5; `running`=1.
- At PC=5 with `brEn`=1, `brTaken`=1, `brOffset`=-3 -> next PC 2. At PC=1020 with `brOffset`=+10 -> PC 6 (wrap).
- At PC=7, `callEn`, `jmpTarget`=100; later `retEn` at PC=103 -> PC 100, then PC 8.
- Five nested calls with DEPTH=4 -> `rasErr`=1 after the fifth; five returns yield last four return addresses, then a sequential step.
- `stall` held 3 cycles at PC=9, with `jmpEn` also high -> PC stays 9 and `instCount` unchanged. After that, `halt` at PC=9 -> PC frozen at 9 and `halted`=1.
- Reset low mid-RUN at PC=40 -> outputs at reset values immediately; PC 0. With `PC_SEQ_RAS_EN` undefined, `retEn` at PC=12 -> PC 13.
